// File: rtl/inst_fetcher_pkg.sv
// Shared fetch/decode definitions: RV32I opcodes, branch/jump immediate
// extraction and the fetch FSM state encoding.
package inst_fetcher_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT_MEM,
    ST_STALL_JALR,
    ST_DISCARD
  } fetch_state_t;

  function automatic logic [6:0] opcode_of(input logic [31:0] inst);
    return inst[6:0];
  endfunction

  // B-type: imm[12|10:5] in [31:25], imm[4:1|11] in [11:7], sign-extended.
  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  // J-type: imm[20|10:1|11|19:12] in [31:12], sign-extended.
  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode: picks the predicted next PC for a fetched word
// (JAL/branches taken, JALR holds the PC until the ROB resolves it).
module fetch_predecode
  import inst_fetcher_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic [31:0] next_pc,
  output logic        is_jalr
);

  always_comb begin
    next_pc = pc + PC_STEP;
    is_jalr = 1'b0;
    case (opcode_of(inst))
      OPC_JAL:    next_pc = pc + imm_j(inst);
      OPC_BRANCH: next_pc = pc + imm_b(inst);
      OPC_JALR: begin
        next_pc = pc;
        is_jalr = 1'b1;
      end
      default:    next_pc = pc + PC_STEP;
    endcase
  end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: one outstanding memory request, predecoded next-PC,
// JALR stall and ROB redirect handling. Define IFETCH_PERF_EN for perf counters.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic [31:0] _clear_pc,
  input  logic        _jalr_done,
  input  logic [31:0] _jalr_target,
  input  logic        _issue_need_inst,
  output logic [31:0] _inst_out,
  output logic        _inst_ready_out,
  output logic [31:0] _inst_addr_out,
  output logic [31:0] _jalr_rd_out,
  output logic        _mem_req,
  output logic [31:0] _mem_addr,
  input  logic        _mem_valid,
  input  logic [31:0] _mem_data
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] _perf_fetched,
  output logic [31:0] _perf_stall_cycles,
  output logic [31:0] _perf_flushes
`endif
);

  fetch_state_t state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  inst_reg;
  logic         inst_ready_reg;
  logic [31:0]  inst_addr_reg;
  logic [31:0]  jalr_rd_reg;
  logic         mem_req_reg;
  logic [31:0]  mem_addr_reg;

  logic [31:0]  pred_next_pc;
  logic         pred_is_jalr;

  fetch_predecode u_predecode (
    .pc      (pc_reg),
    .inst    (_mem_data),
    .next_pc (pred_next_pc),
    .is_jalr (pred_is_jalr)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg      <= ST_FETCH;
      pc_reg         <= RESET_PC;
      inst_reg       <= '0;
      inst_ready_reg <= 1'b0;
      inst_addr_reg  <= '0;
      jalr_rd_reg    <= '0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= RESET_PC;
    end else if (!rdy_in) begin
      inst_ready_reg <= 1'b0;
      mem_req_reg    <= 1'b0;
    end else begin
      inst_ready_reg <= 1'b0;
      mem_req_reg    <= 1'b0;
      if (_clear) begin
        pc_reg <= _clear_pc;
        case (state_reg)
          // The outstanding response must still be swallowed unless it arrives now.
          ST_WAIT_MEM: state_reg <= _mem_valid ? ST_FETCH : ST_DISCARD;
          ST_DISCARD:  state_reg <= _mem_valid ? ST_FETCH : ST_DISCARD;
          default:     state_reg <= ST_FETCH;
        endcase
      end else begin
        case (state_reg)
          ST_FETCH: begin
            if (_issue_need_inst) begin
              mem_req_reg  <= 1'b1;
              mem_addr_reg <= pc_reg;
              state_reg    <= ST_WAIT_MEM;
            end
          end
          ST_WAIT_MEM: begin
            if (_mem_valid) begin
              inst_ready_reg <= 1'b1;
              inst_reg       <= _mem_data;
              inst_addr_reg  <= pc_reg;
              jalr_rd_reg    <= pc_reg + PC_STEP;
              pc_reg         <= pred_next_pc;
              state_reg      <= pred_is_jalr ? ST_STALL_JALR : ST_FETCH;
            end
          end
          ST_STALL_JALR: begin
            if (_jalr_done) begin
              pc_reg    <= _jalr_target & ~32'h1;
              state_reg <= ST_FETCH;
            end
          end
          ST_DISCARD: begin
            if (_mem_valid) begin
              state_reg <= ST_FETCH;
            end
          end
          default: state_reg <= ST_FETCH;
        endcase
      end
    end
  end

  assign _inst_out       = inst_reg;
  assign _inst_ready_out = inst_ready_reg;
  assign _inst_addr_out  = inst_addr_reg;
  assign _jalr_rd_out    = jalr_rd_reg;
  assign _mem_req        = mem_req_reg;
  assign _mem_addr       = mem_addr_reg;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_flushes_reg;

  // Fetch count follows the strobe being launched, so it matches _inst_ready_out pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_fetched_reg <= '0;
      perf_stall_reg   <= '0;
      perf_flushes_reg <= '0;
    end else if (rdy_in) begin
      if (!_clear && state_reg == ST_WAIT_MEM && _mem_valid) begin
        perf_fetched_reg <= perf_fetched_reg + 32'd1;
      end
      if (state_reg == ST_STALL_JALR || (state_reg == ST_FETCH && !_issue_need_inst)) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
      if (_clear) begin
        perf_flushes_reg <= perf_flushes_reg + 32'd1;
      end
    end
  end

  assign _perf_fetched      = perf_fetched_reg;
  assign _perf_stall_cycles = perf_stall_reg;
  assign _perf_flushes      = perf_flushes_reg;
`endif

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher: bench-side memory/ROB, expected strobes
// queued at response time and checked by an independent monitor.
module tb_inst_fetcher;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in, rdy_in, _clear, _jalr_done, _issue_need_inst, _mem_valid;
  logic [31:0] _clear_pc, _jalr_target, _mem_data;
  logic [31:0] _inst_out, _inst_addr_out, _jalr_rd_out, _mem_addr;
  logic        _inst_ready_out, _mem_req;
`ifdef IFETCH_PERF_EN
  logic [31:0] _perf_fetched, _perf_stall_cycles, _perf_flushes;
`endif

  inst_fetcher #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    ._clear           (_clear),
    ._clear_pc        (_clear_pc),
    ._jalr_done       (_jalr_done),
    ._jalr_target     (_jalr_target),
    ._issue_need_inst (_issue_need_inst),
    ._inst_out        (_inst_out),
    ._inst_ready_out  (_inst_ready_out),
    ._inst_addr_out   (_inst_addr_out),
    ._jalr_rd_out     (_jalr_rd_out),
    ._mem_req         (_mem_req),
    ._mem_addr        (_mem_addr),
    ._mem_valid       (_mem_valid),
    ._mem_data        (_mem_data)
`ifdef IFETCH_PERF_EN
    ,
    ._perf_fetched      (_perf_fetched),
    ._perf_stall_cycles (_perf_stall_cycles),
    ._perf_flushes      (_perf_flushes)
`endif
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] link;
  } strobe_t;

  strobe_t     exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_strobe = 0;
  int          n_clear = 0;
  logic [31:0] exp_pc;
  logic [6:0]  other_opc[4] = '{7'b0010011, 7'b0110111, 7'b0000011, 7'b0110011};

  // Monitor: every strobe must match the oldest expected fetch.
  always @(negedge clk_in) begin
    strobe_t e;
    if (!rst_in && _inst_ready_out) begin
      n_vec++;
      n_strobe++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got inst=%h addr=%h, required no strobe", _inst_out, _inst_addr_out);
      end else begin
        e = exp_q.pop_front();
        if (_inst_out !== e.inst || _inst_addr_out !== e.addr || _jalr_rd_out !== e.link) begin
          n_err++;
          $display("FAIL strobe: got inst=%h addr=%h link=%h, required inst=%h addr=%h link=%h",
                   _inst_out, _inst_addr_out, _jalr_rd_out, e.inst, e.addr, e.link);
        end else begin
          $display("txn %0d: inst=%h addr=%h link=%h", n_strobe, _inst_out, _inst_addr_out, _jalr_rd_out);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic expect_req();
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk_in);
      if (_mem_req) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL req_timeout: got no _mem_req in 64 cycles, required request at %h", exp_pc);
      finish_run();
      return;
    end
    check("req_addr", _mem_addr, exp_pc);
  endtask

  // clr_mode: 0 none, 1 clear while waiting, 2 clear together with the response.
  task automatic fetch_one(input logic [31:0] word, input logic [31:0] nxt, input bit is_jalr,
                           input int lat, input int clr_mode, input logic [31:0] clr_pc,
                           input logic [31:0] jt, input bit jclr, input int stall);
    int reqs;
    expect_req();
    if (clr_mode == 1) begin
      _clear = 1'b1; _clear_pc = clr_pc; n_clear++;
    end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk_in);
      _clear = 1'b0;
    end
    _mem_valid = 1'b1;
    _mem_data  = word;
    if (clr_mode == 2) begin
      _clear = 1'b1; _clear_pc = clr_pc; n_clear++;
    end else if (clr_mode == 0) begin
      exp_q.push_back('{inst: word, addr: exp_pc, link: exp_pc + 32'd4});
    end
    @(negedge clk_in);
    _mem_valid = 1'b0;
    _clear     = 1'b0;
    if (clr_mode != 0) begin
      exp_pc = clr_pc;
      return;
    end
    if (!is_jalr) begin
      exp_pc = nxt;
      return;
    end
    reqs = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_in);
      if (_mem_req) reqs++;
    end
    _jalr_done = 1'b1; _jalr_target = jt;
    if (jclr) begin
      _clear = 1'b1; _clear_pc = clr_pc; n_clear++;
    end
    @(negedge clk_in);
    if (_mem_req) reqs++;
    _jalr_done = 1'b0;
    _clear     = 1'b0;
    check("no_req_in_jalr_stall", 32'(reqs), 32'd0);
    exp_pc = jclr ? clr_pc : (jt & 32'hFFFF_FFFE);
  endtask

  task automatic clear_idle(input logic [31:0] pc);
    _clear = 1'b1; _clear_pc = pc; n_clear++;
    @(negedge clk_in);
    _clear = 1'b0;
    exp_pc = pc;
  endtask

  task automatic idle_check(input int cycles, input bit use_rdy);
    int reqs = 0;
    if (use_rdy) rdy_in = 1'b0;
    else _issue_need_inst = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_in);
      if (_mem_req) reqs++;
    end
    rdy_in = 1'b1;
    _issue_need_inst = 1'b1;
    check(use_rdy ? "no_req_rdy_low" : "no_req_need_low", 32'(reqs), 32'd0);
  endtask

  initial begin
    int          kind, lat, cm, simm;
    logic [31:0] w, nxt, cp, jt;
    logic [20:0] ij;
    logic [12:0] ib;
`ifdef IFETCH_PERF_EN
    logic [31:0] stall_before;
`endif
    rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0; _clear_pc = '0;
    _jalr_done = 1'b0; _jalr_target = '0; _issue_need_inst = 1'b1;
    _mem_valid = 1'b0; _mem_data = '0;
    repeat (3) @(negedge clk_in);
    check("rst_inst_ready", 32'(_inst_ready_out), 32'd0);
    check("rst_mem_req", 32'(_mem_req), 32'd0);
    check("rst_inst_out", _inst_out, 32'd0);
    check("rst_inst_addr", _inst_addr_out, 32'd0);
    check("rst_jalr_rd", _jalr_rd_out, 32'd0);
    check("rst_mem_addr", _mem_addr, 32'h0);
    rst_in = 1'b0;
    exp_pc = 32'h0;

    // Directed walk through the basic cases.
    fetch_one(32'h0000_0013, 32'h4, 0, 1, 0, 0, 0, 0, 0);
    clear_idle(32'h10);
    fetch_one(32'h0080_00EF, 32'h18, 0, 1, 0, 0, 0, 0, 0);
    clear_idle(32'h20);
    fetch_one(32'hFE00_0EE3, 32'h1C, 0, 2, 0, 0, 0, 0, 0);
    clear_idle(32'h40);
    fetch_one(32'h0000_80E7, 32'h0, 1, 1, 0, 0, 32'h1235, 0, 4);
    fetch_one(32'h0000_0013, 32'h0, 0, 2, 1, 32'h200, 0, 0, 0);
    fetch_one(32'h0000_80E7, 32'h0, 1, 1, 0, 32'h300, 32'h80, 1, 2);
`ifdef IFETCH_PERF_EN
    stall_before = _perf_stall_cycles;
`endif
    idle_check(10, 0);
`ifdef IFETCH_PERF_EN
    check("perf_stall_delta", _perf_stall_cycles - stall_before, 32'd10);
`endif
    idle_check(3, 1);

    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 3);
      lat  = $urandom_range(1, 3);
      cm   = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0);
      w    = $urandom;
      cp   = $urandom & 32'hFFFF_FFFC;
      jt   = $urandom;
      nxt  = exp_pc + 32'd4;
      case (kind)
        0: w[6:0] = other_opc[$urandom_range(0, 3)];
        1: begin
          ij = 21'($urandom) & 21'h1F_FFFE;
          w[31] = ij[20]; w[30:21] = ij[10:1]; w[20] = ij[11]; w[19:12] = ij[19:12];
          w[6:0] = 7'b1101111;
          simm = ij[20] ? int'(ij) - (1 << 21) : int'(ij);
          nxt = exp_pc + 32'(simm);
        end
        2: begin
          ib = 13'($urandom) & 13'h1FFE;
          w[31] = ib[12]; w[30:25] = ib[10:5]; w[11:8] = ib[4:1]; w[7] = ib[11];
          w[6:0] = 7'b1100011;
          simm = ib[12] ? int'(ib) - (1 << 13) : int'(ib);
          nxt = exp_pc + 32'(simm);
        end
        default: w[6:0] = 7'b1100111;
      endcase
      fetch_one(w, nxt, kind == 3, lat, cm, cp, jt, $urandom_range(0, 4) == 0, $urandom_range(0, 5));
      if ($urandom_range(0, 4) == 0) idle_check($urandom_range(1, 5), 1'($urandom_range(0, 1)));
    end
    expect_req();

    repeat (5) @(negedge clk_in);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef IFETCH_PERF_EN
    check("perf_fetched", _perf_fetched, 32'(n_strobe));
    check("perf_flushes", _perf_flushes, 32'(n_clear));
`endif
    finish_run();
  end

endmodule
